// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing with pixel-request port and
//            built-in test patterns, all in the pixel clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int              H_SYNC    = 128,
    parameter int              H_BACK    = 88,
    parameter int              H_ACT     = 800,
    parameter int              H_FRONT   = 40,
    parameter int              V_SYNC    = 4,
    parameter int              V_BACK    = 23,
    parameter int              V_ACT     = 600,
    parameter int              V_FRONT   = 1,
    parameter bit              HS_POL    = 1'b1,
    parameter bit              VS_POL    = 1'b1,
    parameter int              CW        = 8,
    parameter int              CNT_W     = 12,
    parameter logic [3*CW-1:0] SOLID_RGB = 24'hFF3030
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   pix_data,
    output logic              pix_req,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              vga_blank_n,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b,
    output logic              frame_start,
    output logic              running
);

    localparam int               c_H_TOTAL   = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int               c_V_TOTAL   = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam logic [CNT_W-1:0] c_H_LAST    = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST    = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] c_H_ACT_BEG = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] c_H_ACT_END = CNT_W'(H_SYNC + H_BACK + H_ACT);
    localparam logic [CNT_W-1:0] c_V_ACT_BEG = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] c_V_ACT_END = CNT_W'(V_SYNC + V_BACK + V_ACT);
    localparam logic [CNT_W-1:0] c_BAR_LAST  = CNT_W'(H_ACT / 8 - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_h_cnt;
    logic [CNT_W-1:0]  r_v_cnt;
    logic [1:0]        r_mode_q;
    logic              r_hs_act;
    logic              r_vs_act;
    logic [2:0]        r_bar_k;
    logic [CNT_W-1:0]  r_bar_cnt;
    logic              w_run;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_frame_last;
    logic              w_active;
    logic [3*CW-1:0]   w_rgb;

    assign w_run        = (r_state == c_ST_RUN);
    assign w_h_last     = (r_h_cnt == c_H_LAST);
    assign w_v_last     = (r_v_cnt == c_V_LAST);
    assign w_frame_last = w_h_last && w_v_last;
    assign w_active     = w_run &&
                          (r_h_cnt >= c_H_ACT_BEG) && (r_h_cnt < c_H_ACT_END) &&
                          (r_v_cnt >= c_V_ACT_BEG) && (r_v_cnt < c_V_ACT_END);
    assign vga_blank_n  = vga_de;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // en only matters at the last pixel, so a frame in progress always completes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (en) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_frame_last && !en) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        running = (r_state == c_ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt  <= '0;
            r_v_cnt  <= '0;
            r_mode_q <= 2'd0;
        end else begin
            if (!w_run) begin
                r_h_cnt <= '0;
                r_v_cnt <= '0;
            end else if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + c_ONE;
            end else begin
                r_h_cnt <= r_h_cnt + c_ONE;
            end
            if (!w_run || w_frame_last) begin
                r_mode_q <= mode;
            end
        end
    end

    // Stage 1: request, coordinates, sync qualifiers and bar tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            r_hs_act    <= 1'b0;
            r_vs_act    <= 1'b0;
            r_bar_k     <= 3'd0;
            r_bar_cnt   <= '0;
        end else begin
            pix_req     <= w_active;
            pix_x       <= w_active ? r_h_cnt - c_H_ACT_BEG : '0;
            pix_y       <= w_active ? r_v_cnt - c_V_ACT_BEG : '0;
            frame_start <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
            r_hs_act    <= w_run && (r_h_cnt < c_H_SYNC_END);
            r_vs_act    <= w_run && (r_v_cnt < c_V_SYNC_END);
            if (w_active) begin
                if (r_h_cnt == c_H_ACT_BEG) begin
                    r_bar_k   <= 3'd0;
                    r_bar_cnt <= '0;
                end else if (r_bar_cnt == c_BAR_LAST) begin
                    r_bar_k   <= r_bar_k + 3'd1;
                    r_bar_cnt <= '0;
                end else begin
                    r_bar_cnt <= r_bar_cnt + c_ONE;
                end
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        case (r_mode_q)
            2'd0:    w_rgb = SOLID_RGB;
            2'd1:    w_rgb = {{CW{r_bar_k[2]}}, {CW{r_bar_k[1]}}, {CW{r_bar_k[0]}}};
            2'd2:    w_rgb = (pix_x[5] ^ pix_y[5]) ? {3*CW{1'b1}} : {3*CW{1'b0}};
            default: w_rgb = pix_data;
        endcase
        if (!pix_req) begin
            w_rgb = '0;
        end
    end

    // Stage 2: pin-facing registers; external data is captured here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
            vga_de <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= r_hs_act ? HS_POL : ~HS_POL;
            vga_vs <= r_vs_act ? VS_POL : ~VS_POL;
            vga_de <= pix_req;
            {vga_r, vga_g, vga_b} <= w_rgb;
        end
    end

endmodule
`default_nettype wire
